// File: rtl/issue_sequencer.sv
// In-order issue sequencer: valid/ready intake, one-deep registered issue, RAW/branch/reset stalls.
// Optional perf counters (issueCount, stallCount) enabled by defining ISSUE_SEQ_PERF_EN.
module issue_sequencer #(
  parameter int WB_LATENCY   = 3,
  parameter int RESET_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instrValid,
  input  logic [63:0] instruction,
  output logic        instrReady,
  output logic        issueValid,
  output logic [63:0] issueInstruction,
  input  logic        branchResolved,
  input  logic        branchTaken,
  output logic        pcRedirect,
  output logic        busy
`ifdef ISSUE_SEQ_PERF_EN
  ,
  output logic [31:0] issueCount,
  output logic [31:0] stallCount
`endif
);

  typedef enum logic [1:0] {RUN, BRANCH_WAIT, RESET_HOLD} state_t;

  localparam logic [3:0] RST_CNT = 4'(RESET_CYCLES);

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic redirect_nxt;

  logic is_branch, is_reset, writes_rf, reads_rf;
  logic [7:0] dest, src_a, src_b;

  // One slot per cycle of writeback latency; slot WB_LATENCY-1 retires next edge.
  logic [WB_LATENCY-1:0]      vld_pipe;
  logic [WB_LATENCY-1:0][7:0] sb_addr;
  logic sb_hit, sb_empty, hazard, accept;

  assign dest  = instruction[55:48];
  assign src_a = instruction[47:40];
  assign src_b = instruction[39:32];

  assign is_branch = instruction[57:56] != 2'b11;
  assign is_reset  = !is_branch && instruction[59:58] != 2'b10 &&
                     (instruction[63:62] == 2'b00 || instruction[63:62] == 2'b11);
  assign writes_rf = !is_branch && instruction[59:58] != 2'b10 && instruction[63:62] == 2'b01;
  assign reads_rf  = is_branch || instruction[63:62] == 2'b10;

  always_comb begin
    sb_hit = 1'b0;
    for (int i = 0; i < WB_LATENCY; i++)
      if (vld_pipe[i] && (sb_addr[i] == src_a || sb_addr[i] == src_b)) sb_hit = 1'b1;
  end

  assign sb_empty   = ~|vld_pipe;
  assign hazard     = reads_rf && sb_hit;
  // Reset-class ops wait for all in-flight writes so nothing lands after the clear.
  assign instrReady = (state == RUN) && !hazard && !(is_reset && !sb_empty);
  assign accept     = instrValid && instrReady;
  assign busy       = (state != RUN) || !sb_empty;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    redirect_nxt = 1'b0;
    case (state)
      RUN: begin
        if (accept && is_branch) begin
          state_nxt = BRANCH_WAIT;
        end else if (accept && is_reset) begin
          state_nxt = RESET_HOLD;
          cnt_nxt   = RST_CNT;
        end
      end
      BRANCH_WAIT: begin
        if (branchResolved) begin
          state_nxt    = RUN;
          redirect_nxt = branchTaken;
        end
      end
      RESET_HOLD: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RUN;
      cnt              <= '0;
      pcRedirect       <= 1'b0;
      issueValid       <= 1'b0;
      issueInstruction <= '0;
      vld_pipe         <= '0;
      sb_addr          <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pcRedirect <= redirect_nxt;
      issueValid <= accept;
      if (accept) issueInstruction <= instruction;
      for (int i = WB_LATENCY - 1; i > 0; i--) begin
        vld_pipe[i] <= vld_pipe[i-1];
        sb_addr[i]  <= sb_addr[i-1];
      end
      vld_pipe[0] <= accept && writes_rf;
      sb_addr[0]  <= dest;
    end
  end

`ifdef ISSUE_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      issueCount <= '0;
      stallCount <= '0;
    end else begin
      if (accept) issueCount <= issueCount + 32'd1;
      if (instrValid && !instrReady) stallCount <= stallCount + 32'd1;
    end
  end
`endif

endmodule

// File: doc/issue_sequencer.md
Name: issue_sequencer

Overview:
- Sits between the instruction source and datapathController.
- Accepts 64-bit instructions over a valid/ready handshake and issues them one at a time on a registered issue port.
- Stalls issue for register-file RAW hazards, branch resolution and register-file/memory reset operations.
- Tracks in-flight register writes with a shift-register scoreboard.

Parameters:
- WB_LATENCY, 3, cycles from issueValid to register-file writeback; scoreboard depth; legal range 1..8.
- RESET_CYCLES, 2, cycles instrReady stays low after issuing a reset-class instruction; legal range 1..15.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- instrValid  input  1  instruction offered.
- instruction  input  64  offered instruction.
- instrReady  output  1  sequencer accepts this cycle; combinational from state and scoreboard.
- issueValid  output  1  one-cycle pulse; issueInstruction is valid.
- issueInstruction  output  64  registered copy of the accepted instruction.
- branchResolved  input  1  one-cycle pulse from the datapath: branch compare done.
- branchTaken  input  1  PCChangeEnable value, sampled only with branchResolved.
- pcRedirect  output  1  one-cycle pulse when a resolved branch is taken.
- busy  output  1  state is not RUN, or any scoreboard slot is valid.

Behaviour:
- Reset is synchronous and active-high; one clock, clk.
- Decode, applied to the offered instruction:
  - isBranch = [57:56] != 2'b11.
  - isReset = ![isBranch] && [59:58] != 2'b10 && ([63:62] == 2'b00 || [63:62] == 2'b11).
  - writesRF = ![isBranch] && [59:58] != 2'b10 && [63:62] == 2'b01; destination is [55:48].
  - readsRF = isBranch || [63:62] == 2'b10; sources are [47:40] and [39:32].
- Scoreboard:
  - WB_LATENCY slots, each {valid, addr[7:0]}; shifts one slot per cycle and the oldest slot retires.
  - On an accept, slot0 <= {writesRF, [55:48]}; otherwise slot0 <= {0, x}.
  - hazard = readsRF && any valid slot addr equals srcA or srcB.
- States: RUN, BRANCH_WAIT, RESET_HOLD.
- instrReady = (state == RUN) && !hazard && !(isReset && scoreboard non-empty).
  - instrReady is evaluated against the offered instruction even when instrValid = 0.
- Accept = instrValid && instrReady. Next cycle: issueValid = 1 and issueInstruction = the accepted instruction (latency 1).
  - issueInstruction holds its last value when issueValid = 0.
- RUN transitions:
  - accept && isBranch -> BRANCH_WAIT.
  - accept && isReset -> RESET_HOLD, counter loaded with RESET_CYCLES.
  - otherwise stay in RUN.
- BRANCH_WAIT:
  - instrReady = 0.
  - On branchResolved: pcRedirect = branchTaken in the next cycle; state -> RUN in the same cycle.
  - The next instruction may be accepted the cycle after branchResolved.
  - No timeout: the sequencer waits indefinitely.
- RESET_HOLD:
  - instrReady = 0; counter decrements each cycle.
  - When counter == 1, state -> RUN.
- branchResolved outside BRANCH_WAIT is ignored; pcRedirect stays 0.
- A stall holds the offered instruction; the source must keep instrValid and instruction stable until accept.
- reset values: state = RUN; all scoreboard slots invalid; issueValid = 0; issueInstruction = 0; pcRedirect = 0; counter = 0; busy = 0.
- reset asserted mid-branch or mid-hold aborts to RUN. In-flight scoreboard entries are discarded; no retire side effects.
- An instruction that is both readsRF and writesRF is impossible by decode; no special case.
- A destination of 8'h00 is tracked like any other address.

Optional Feature:
- Macro: ISSUE_SEQ_PERF_EN.
- When defined, adds output issueCount[31:0]: increments on every accept and wraps at 2^32.
- When defined, adds output stallCount[31:0]: increments every cycle instrValid && !instrReady; wraps.
- Both counters reset to 0.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Back-to-back independent ALU ops (dest 8'h05 then srcA 8'h06/srcB 8'h07) -> two accepts on consecutive cycles; issueValid high 2 cycles, each 1 cycle after its accept.
- Load to 8'h10 ([63:62] = 01, [57:56] = 11), then a store reading 8'h10 ([63:62] = 10) -> store instrReady low for exactly WB_LATENCY = 3 cycles after the load accept, then accepted.
- Branch issued, branchResolved with branchTaken = 1 four cycles later -> instrReady low throughout; pcRedirect pulses once the next cycle; the following instruction is accepted the cycle after branchResolved.
- Memory reset ([63:62] = 11, [57:56] = 11, [59:58] = 00) offered with 2 writes in flight -> held until the scoreboard is empty, then accepted; instrReady low for RESET_CYCLES = 2 cycles.
- reset asserted during BRANCH_WAIT -> next cycle state RUN, busy = 0, issueValid = 0; a later stray branchResolved produces no pcRedirect.
- With ISSUE_SEQ_PERF_EN: 5 accepts and 3 stall cycles -> issueCount = 5, stallCount = 3.
